br_predictor_gshare: RTL and testbench
======================================

# br_predictor_gshare

Parametrised next-generation branch predictor sitting between the instruction fetcher and the reorder buffer. It combines a gshare pattern history table (2-bit saturating counters indexed by PC XOR global history), static JAL target computation, and a return address stack (RAS) for JALR returns. Prediction is combinational in the fetch cycle; counter training and history updates come from committed branches on the ROB bus.

## Interface
- PHT_IDX_BITS, 8: log2 of PHT entries (256 counters).
- GHR_BITS, 8: global history length; must be <= PHT_IDX_BITS.
- RAS_DEPTH, 8: RAS entries; power of 2, >= 2.
- PHT_INIT, 1: reset value of every counter (0..3).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global enable; low freezes all state.
- fetch_valid  in  1  fetch_inst/fetch_pc describe a real fetched instruction this cycle.
- fetch_inst  in  32  fetched instruction word.
- fetch_pc  in  32  address of fetch_inst.
- next_pc  out  32  predicted address of the following instruction.
- pred_taken  out  1  1 when next_pc != fetch_pc+4 by prediction (JAL, taken branch, RAS hit).
- commit_valid  in  1  a conditional branch commits this cycle.
- commit_pc  in  32  PC of the committing branch.
- commit_taken  in  1  actual outcome of that branch.
- flush  in  1  pipeline flush (mispredict recovery); clears the RAS.

## Operation
- Decode of fetch_inst: JAL (opcode 1101111), JALR (1100111), BRANCH (1100011); link register = x1 or x5.
- PHT index (fetch) = fetch_pc[PHT_IDX_BITS+1:2] XOR zero-extended GHR; index (commit) = commit_pc[PHT_IDX_BITS+1:2] XOR GHR, both using the current committed GHR.
- next_pc priority: JAL -> fetch_pc + J-imm; JALR with pop (see below) and RAS non-empty -> RAS top; BRANCH with counter >= 2 -> fetch_pc + B-imm; otherwise fetch_pc + 4. All adds modulo 2^32; immediates sign-extended to 32 bits, bit 0 = 0.
- pred_taken = 1 for first three cases, else 0; independent of fetch_valid.
- RAS actions (only when fetch_valid, rdy, !flush, !rst):
  - push pc+4: JAL with rd=link; JALR with rd=link.
  - pop: JALR with rs1=link and rd!=link.
  - JALR rd=link, rs1=link, rs1!=rd: pop then push (top replaced by pc+4, count unchanged).
  - JALR rd=link, rs1==rd: push only, predicted pc+4.
- RAS is circular: top pointer + count (0..RAS_DEPTH). Push when full overwrites oldest entry, count stays RAS_DEPTH. Pop when empty: no-op, prediction falls through to pc+4.
- Commit (commit_valid, rdy, !rst): counter at commit index increments saturating at 3 if taken, decrements saturating at 0 if not; GHR <= {GHR[GHR_BITS-2:0], commit_taken}. Index computed from pre-shift GHR.
- flush (rdy high): RAS count and pointer to 0. GHR and PHT untouched; a simultaneous commit still applies.

## Timing
- Reset (rst high at posedge): all PHT counters = PHT_INIT, GHR = 0, RAS count = 0, top = 0. Outputs are combinational: after reset, BRANCH predicts not-taken when PHT_INIT < 2, JALR predicts pc+4.
- Prediction latency 0 cycles: next_pc/pred_taken valid in the same cycle as fetch inputs.
- All state updates take effect at the next posedge; a prediction in cycle N sees commits and RAS pushes from cycles <= N-1.
- Same-index commit and fetch in one cycle: fetch uses the old counter.
- rdy low: no state changes (including rst ignored? no: rst has priority over rdy); outputs still track inputs.
- Precedence per cycle: rst > !rdy freeze > flush (RAS) ; commit independent of flush.

## Test plan
- Reset, then BRANCH at 0x100 with B-imm +16 -> next_pc=0x104, pred_taken=0; two commits taken at 0x100 with GHR kept at 0 (GHR_BITS held via alternating index check) -> counter 3, next fetch predicts 0x110.
- JAL at 0x200 imm -0x20 -> next_pc=0x1E0, pred_taken=1, RAS unchanged when rd=x0; rd=x1 -> RAS count 1, top=0x204.
- Call chain: 9 pushes with RAS_DEPTH=8 then 9 returns (jalr x0,0(x1)) -> first 8 predict pushed addresses in LIFO order (oldest lost), 9th predicts pc+4.
- Counter saturation: 5 not-taken commits on counter at 0 stays 0; 5 taken from 3 stays 3; GHR after commits T,N,T = 3'b101 in low bits.
- flush asserted same cycle as a call fetch -> no push, RAS count 0; same cycle as commit -> counter still updated.
- rdy=0 for 3 cycles with commit_valid and call fetches -> PHT, GHR, RAS identical before/after; rst during rdy=0 still resets.

Source files
------------

// File: rtl/br_predictor_gshare.sv
// ---------------------------------------------------------------------------
// br_predictor_gshare
//
// Next-PC predictor that sits between instruction fetch and the reorder buffer.
//   - gshare PHT: 2-bit saturating counters, indexed by PC XOR global history.
//   - JAL targets are computed statically from the J-immediate.
//   - Return address stack (RAS) predicts JALR returns.
// Prediction is purely combinational in the fetch cycle. Counters and global
// history are trained only by committed conditional branches.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   rdy           global enable; low freezes every piece of state
//   fetch_valid   fetch_inst/fetch_pc describe a real instruction this cycle
//   fetch_inst    fetched instruction word
//   fetch_pc      address of fetch_inst
//   next_pc       predicted address of the following instruction
//   pred_taken    next_pc differs from fetch_pc+4 by prediction
//   commit_valid  a conditional branch commits this cycle
//   commit_pc     PC of the committing branch
//   commit_taken  resolved outcome of that branch
//   flush         mispredict recovery; empties the RAS
// ---------------------------------------------------------------------------
module br_predictor_gshare #(
    parameter int PHT_IDX_BITS = 8,   // log2 of PHT entries
    parameter int GHR_BITS     = 8,   // global history length, <= PHT_IDX_BITS
    parameter int RAS_DEPTH    = 8,   // power of 2, >= 2
    parameter int PHT_INIT     = 1    // reset value of every counter (0..3)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_inst,
    input  logic [31:0] fetch_pc,
    output logic [31:0] next_pc,
    output logic        pred_taken,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic        commit_taken,
    input  logic        flush
);

    localparam int PHT_SIZE  = 1 << PHT_IDX_BITS;
    localparam int RAS_PTR_W = $clog2(RAS_DEPTH);
    localparam int RAS_CNT_W = $clog2(RAS_DEPTH + 1);

    localparam logic [1:0]           CTR_INIT = 2'(PHT_INIT);
    localparam logic [RAS_CNT_W-1:0] RAS_FULL = RAS_CNT_W'(RAS_DEPTH);

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]           r_pht [PHT_SIZE];
    logic [GHR_BITS-1:0]  r_ghr;
    logic [31:0]          r_ras [RAS_DEPTH];
    logic [RAS_PTR_W-1:0] r_ras_top;   // slot holding the current top entry
    logic [RAS_CNT_W-1:0] r_ras_cnt;   // valid entries, 0..RAS_DEPTH

    // ------------------------------------------------------------------
    // Fetch-side decode
    // ------------------------------------------------------------------
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic        w_is_jal;
    logic        w_is_jalr;
    logic        w_is_br;
    logic        w_rd_link;
    logic        w_rs1_link;
    logic [31:0] w_j_imm;
    logic [31:0] w_b_imm;
    logic [31:0] w_pc_plus4;

    assign w_rd       = fetch_inst[11:7];
    assign w_rs1      = fetch_inst[19:15];
    assign w_is_jal   = (fetch_inst[6:0] == OP_JAL);
    assign w_is_jalr  = (fetch_inst[6:0] == OP_JALR);
    assign w_is_br    = (fetch_inst[6:0] == OP_BRANCH);
    assign w_rd_link  = (w_rd  == 5'd1) || (w_rd  == 5'd5);
    assign w_rs1_link = (w_rs1 == 5'd1) || (w_rs1 == 5'd5);

    assign w_j_imm = {{12{fetch_inst[31]}}, fetch_inst[19:12], fetch_inst[20],
                      fetch_inst[30:21], 1'b0};
    assign w_b_imm = {{20{fetch_inst[31]}}, fetch_inst[7], fetch_inst[30:25],
                      fetch_inst[11:8], 1'b0};
    assign w_pc_plus4 = fetch_pc + 32'd4;

    // Calls push their link address; returns pop. A JALR whose rd and rs1
    // are both link registers but different is a coroutine swap: it pops and
    // pushes. When rd == rs1 it is treated as a plain call.
    logic w_ras_push;
    logic w_ras_pop;
    logic w_ras_empty;

    assign w_ras_push  = (w_is_jal || w_is_jalr) && w_rd_link;
    assign w_ras_pop   = w_is_jalr && w_rs1_link && (!w_rd_link || (w_rd != w_rs1));
    assign w_ras_empty = (r_ras_cnt == '0);

    // ------------------------------------------------------------------
    // PHT indexing (both sides use the current committed history)
    // ------------------------------------------------------------------
    logic [PHT_IDX_BITS-1:0] w_fetch_idx;
    logic [PHT_IDX_BITS-1:0] w_commit_idx;
    logic [1:0]              w_fetch_ctr;
    logic [1:0]              w_commit_ctr;
    logic [1:0]              w_commit_ctr_nxt;

    assign w_fetch_idx  = fetch_pc[PHT_IDX_BITS+1:2]  ^ PHT_IDX_BITS'(r_ghr);
    assign w_commit_idx = commit_pc[PHT_IDX_BITS+1:2] ^ PHT_IDX_BITS'(r_ghr);
    assign w_fetch_ctr  = r_pht[w_fetch_idx];
    assign w_commit_ctr = r_pht[w_commit_idx];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        w_commit_ctr_nxt = w_commit_ctr;
        if (commit_taken) begin
            if (w_commit_ctr != 2'd3) w_commit_ctr_nxt = w_commit_ctr + 2'd1;
        end else begin
            if (w_commit_ctr != 2'd0) w_commit_ctr_nxt = w_commit_ctr - 2'd1;
        end
    end

    // Only the index bits of commit_pc matter to the predictor.
    logic w_unused_commit_pc;
    assign w_unused_commit_pc = &{1'b0, commit_pc[31:PHT_IDX_BITS+2], commit_pc[1:0]};

    // ------------------------------------------------------------------
    // Next-PC selection (combinational, independent of fetch_valid)
    // ------------------------------------------------------------------
    always_comb begin
        next_pc    = w_pc_plus4;
        pred_taken = 1'b0;
        if (w_is_jal) begin
            next_pc    = fetch_pc + w_j_imm;
            pred_taken = 1'b1;
        end else if (w_is_jalr && w_ras_pop && !w_ras_empty) begin
            next_pc    = r_ras[r_ras_top];
            pred_taken = 1'b1;
        end else if (w_is_br && w_fetch_ctr[1]) begin
            next_pc    = fetch_pc + w_b_imm;
            pred_taken = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // RAS update control
    // ------------------------------------------------------------------
    logic                 w_ras_act;
    logic                 w_ras_replace;   // pop+push on a non-empty stack
    logic                 w_ras_push_new;  // push that advances the pointer
    logic                 w_ras_pop_only;
    logic [RAS_PTR_W-1:0] w_ras_wr_idx;

    assign w_ras_act      = rdy && fetch_valid && !flush;
    assign w_ras_replace  = w_ras_act && w_ras_push && w_ras_pop && !w_ras_empty;
    assign w_ras_push_new = w_ras_act && w_ras_push && !w_ras_replace;
    assign w_ras_pop_only = w_ras_act && w_ras_pop && !w_ras_push && !w_ras_empty;
    // Advancing onto the next slot when full overwrites the oldest entry.
    assign w_ras_wr_idx   = w_ras_replace ? r_ras_top : r_ras_top + RAS_PTR_W'(1);

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            for (int i = 0; i < PHT_SIZE; i++) r_pht[i] <= CTR_INIT;
            r_ghr     <= '0;
            r_ras_top <= '0;
            r_ras_cnt <= '0;
        end else if (rdy) begin
            if (commit_valid) begin
                r_pht[w_commit_idx] <= w_commit_ctr_nxt;
                r_ghr               <= GHR_BITS'({r_ghr, commit_taken});
            end
            if (flush) begin
                r_ras_top <= '0;
                r_ras_cnt <= '0;
            end else if (w_ras_push_new) begin
                r_ras_top <= r_ras_top + RAS_PTR_W'(1);
                if (r_ras_cnt != RAS_FULL) r_ras_cnt <= r_ras_cnt + RAS_CNT_W'(1);
            end else if (w_ras_pop_only) begin
                r_ras_top <= r_ras_top - RAS_PTR_W'(1);
                r_ras_cnt <= r_ras_cnt - RAS_CNT_W'(1);
            end
        end
    end

    // NOTE: the RAS storage has no reset; an entry is only ever read while the count covers it, so its power-up contents never matter.
    always_ff @(posedge clk) begin
        if (!rst && (w_ras_replace || w_ras_push_new)) begin
            r_ras[w_ras_wr_idx] <= w_pc_plus4;
        end
    end

endmodule

// File: tb/tb_br_predictor_gshare.sv
// ---------------------------------------------------------------------------
// tb_br_predictor_gshare
//
// Directed bench for br_predictor_gshare with default parameters
// (256-entry PHT, 8-bit history, 8-deep RAS, counters reset to 1).
// Expected next_pc/pred_taken values are hand-derived constants; the
// instruction encoders below only build the stimulus words.
// ---------------------------------------------------------------------------
module tb_br_predictor_gshare;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        fetch_valid;
    logic [31:0] fetch_inst;
    logic [31:0] fetch_pc;
    logic [31:0] next_pc;
    logic        pred_taken;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        commit_taken;
    logic        flush;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    br_predictor_gshare dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .fetch_valid  (fetch_valid),
        .fetch_inst   (fetch_inst),
        .fetch_pc     (fetch_pc),
        .next_pc      (next_pc),
        .pred_taken   (pred_taken),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_taken (commit_taken),
        .flush        (flush)
    );

    always #5 clk = ~clk;

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [31:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b000, rd, 7'b1100111};
    endfunction

    function automatic logic [31:0] enc_br(input logic [31:0] imm);
        return {imm[12], imm[10:5], 5'd0, 5'd0, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_pred(input string tag, input logic [31:0] exp_pc, input logic exp_tk);
        check({tag, ".next_pc"}, next_pc, exp_pc);
        check({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, exp_tk});
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] inst);
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        fetch_inst  = inst;
        #1;
    endtask

    task automatic commit(input logic [31:0] pc, input logic taken);
        commit_valid = 1'b1;
        commit_pc    = pc;
        commit_taken = taken;
        #1;
    endtask

    // One clock edge, then drop all per-cycle strobes.
    task automatic cycle();
        @(posedge clk);
        #1;
        fetch_valid  = 1'b0;
        fetch_inst   = NOP;
        commit_valid = 1'b0;
        flush        = 1'b0;
    endtask

    logic [31:0] br16;
    logic [31:0] ret;
    logic [31:0] sat_t_pcs  [5];
    logic [31:0] sat_nt_pcs [6];

    initial begin
        br16 = enc_br(32'd16);
        ret  = enc_jalr(5'd0, 5'd1);
        sat_t_pcs  = '{32'h10C, 32'h11C, 32'h13C, 32'h17C, 32'h1FC};
        sat_nt_pcs = '{32'h3B8, 32'h3B0, 32'h3A0, 32'h380, 32'h3C0, 32'h340};

        rst = 1'b1; rdy = 1'b1;
        fetch_valid = 1'b0; fetch_inst = NOP; fetch_pc = '0;
        commit_valid = 1'b0; commit_pc = '0; commit_taken = 1'b0; flush = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;

        // ---- reset state: counters weakly not-taken, RAS empty ----
        fetch(32'h100, br16);
        check_pred("rst_branch", 32'h104, 1'b0);
        fetch(32'h300, ret);
        check_pred("rst_jalr", 32'h304, 1'b0);

        // ---- training idx 0x40; same-cycle fetch sees old counter ----
        fetch(32'h100, br16);
        commit(32'h100, 1'b1);
        check_pred("same_idx_old", 32'h104, 1'b0);
        cycle();                                   // ctr[40]=2, ghr=01
        fetch(32'h104, br16);                      // idx 41^01 = 40
        check_pred("ctr2_taken", 32'h114, 1'b1);
        commit(32'h104, 1'b1);
        cycle();                                   // ctr[40]=3, ghr=03
        fetch(32'h10C, br16);                      // idx 43^03 = 40
        check_pred("ctr3_taken", 32'h11C, 1'b1);
        fetch(32'h100, br16);                      // idx 40^03 = 43
        check_pred("ghr_xor", 32'h104, 1'b0);

        // ---- 5 taken commits on idx 0x40 already at 3 ----
        for (int k = 0; k < 5; k++) begin
            commit(sat_t_pcs[k], 1'b1);
            cycle();
        end                                        // ghr=7F
        fetch(32'h0FC, br16);                      // idx 3F^7F = 40
        check_pred("sat_hi", 32'h10C, 1'b1);
        commit(32'h0FC, 1'b0);
        cycle();                                   // ctr[40]=2, ghr=FE
        fetch(32'h2F8, br16);                      // idx BE^FE = 40
        check_pred("sat_hi_dec", 32'h308, 1'b1);

        // ---- idx 0x10: 1 -> 0, then 5 more not-taken stays 0 ----
        for (int k = 0; k < 6; k++) begin
            commit(sat_nt_pcs[k], 1'b0);
            cycle();
        end                                        // ghr=80
        fetch(32'h240, br16);                      // idx 90^80 = 10
        check_pred("sat_lo", 32'h244, 1'b0);

        // ---- history T,N,T -> ghr=05 ----
        commit(32'h0, 1'b1); cycle();
        commit(32'h0, 1'b0); cycle();
        commit(32'h0, 1'b1); cycle();
        fetch(32'h114, br16);                      // idx 45^05 = 40 (ctr 2)
        check_pred("ghr_tnt", 32'h124, 1'b1);
        fetch(32'h100, br16);                      // idx 40^05 = 45 (ctr 1)
        check_pred("ghr_tnt_alt", 32'h104, 1'b0);

        // ---- JAL: static target, link push only for rd=x1 ----
        fetch(32'h200, enc_jal(5'd0, 32'hFFFF_FFE0));
        check_pred("jal_x0", 32'h1E0, 1'b1);
        cycle();
        fetch(32'h300, ret);
        check_pred("ret_after_x0", 32'h304, 1'b0);
        cycle();
        fetch(32'h200, enc_jal(5'd1, 32'hFFFF_FFE0));
        check_pred("jal_x1", 32'h1E0, 1'b1);
        cycle();
        fetch(32'h300, ret);
        check_pred("ret_after_x1", 32'h204, 1'b1);
        cycle();

        // ---- call chain deeper than the RAS ----
        for (int k = 0; k < 9; k++) begin
            fetch(32'h1000 + 32'(16 * k), enc_jal(5'd1, 32'h100));
            cycle();
        end
        for (int k = 0; k < 8; k++) begin
            fetch(32'h300, ret);
            check_pred($sformatf("chain_ret%0d", k), 32'h1004 + 32'(16 * (8 - k)), 1'b1);
            cycle();
        end
        fetch(32'h300, ret);
        check_pred("chain_ret8", 32'h304, 1'b0);
        cycle();

        // ---- coroutine swap: pop then push, count unchanged ----
        fetch(32'h500, enc_jal(5'd1, 32'h40));
        cycle();
        fetch(32'h600, enc_jalr(5'd1, 5'd5));
        check_pred("swap_pred", 32'h504, 1'b1);
        cycle();
        fetch(32'h700, ret);
        check_pred("swap_top", 32'h604, 1'b1);
        cycle();
        fetch(32'h700, ret);
        check_pred("swap_empty", 32'h704, 1'b0);
        cycle();

        // ---- jalr x1,0(x1): push only, predicts pc+4 ----
        fetch(32'h800, enc_jalr(5'd1, 5'd1));
        check_pred("jalr_rd_eq_rs1", 32'h804, 1'b0);
        cycle();
        fetch(32'h700, ret);
        check_pred("jalr_rd_eq_rs1_ret", 32'h804, 1'b1);
        cycle();

        // ---- flush with a call fetch and a commit in the same cycle ----
        fetch(32'h900, enc_jal(5'd1, 32'h40));
        commit(32'h094, 1'b1);                     // idx 25^05 = 20, 1 -> 2; ghr=0B
        flush = 1'b1;
        #1;
        check_pred("flush_jal", 32'h940, 1'b1);
        cycle();
        fetch(32'h300, ret);
        check_pred("flush_no_push", 32'h304, 1'b0);
        cycle();
        fetch(32'h0AC, br16);                      // idx 2B^0B = 20
        check_pred("flush_commit", 32'h0BC, 1'b1);

        fetch(32'hA00, enc_jal(5'd1, 32'h40));
        cycle();
        flush = 1'b1;
        #1;
        cycle();
        fetch(32'h300, ret);
        check_pred("flush_clears", 32'h304, 1'b0);
        cycle();

        // ---- rdy low freezes PHT, GHR and RAS ----
        fetch(32'hB00, enc_jal(5'd1, 32'h40));
        cycle();                                   // RAS top = B04
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            fetch(32'hC00 + 32'(16 * k), enc_jal(5'd1, 32'h40));
            commit(32'h0AC, 1'b0);
            check_pred($sformatf("frozen_out%0d", k), 32'hC40 + 32'(16 * k), 1'b1);
            cycle();
        end
        rdy = 1'b1;
        fetch(32'h0AC, br16);
        check_pred("freeze_pht_ghr", 32'h0BC, 1'b1);
        fetch(32'h300, ret);
        check_pred("freeze_ras", 32'hB04, 1'b1);

        // ---- reset wins over rdy low ----
        fetch_valid = 1'b0;
        rdy = 1'b0;
        rst = 1'b1;
        #1;
        cycle();
        rst = 1'b0;
        rdy = 1'b1;
        fetch(32'h300, ret);
        check_pred("rst_frozen_ras", 32'h304, 1'b0);
        fetch(32'h0AC, br16);                      // ghr=0 -> idx 2B, ctr 1
        check_pred("rst_frozen_pht", 32'h0B0, 1'b0);
        fetch_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
